// File: rtl/spi_fetch_unit.sv
// spi_fetch_unit
// Sequences NBYTES single-byte reads on spi_read_byte for one core fetch and
// returns them as one big-endian word (byte at the request address in the MSBs).
// A per-byte watchdog turns a hung SPI transfer into an error response, after
// which the unit drains the stale completion before accepting new work.
// Optional feature macro: SPI_FETCH_PREFETCH_EN (speculative next-word prefetch).
module spi_fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int NBYTES  = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [8*NBYTES-1:0]  rsp_data,
    output logic                 rsp_err,
    output logic                 rd_start,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic                 rd_done,
    input  logic [7:0]           rd_data
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q,  base_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic [8*NBYTES-1:0] asm_q,   asm_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                err_q,   err_d;

    logic                req_fire;
    logic                last_byte;
    logic                timed_out;
    logic [8*NBYTES-1:0] asm_with_byte;

`ifdef SPI_FETCH_PREFETCH_EN
    // Prefetch bookkeeping. The assembly register doubles as the one-word
    // buffer and base_q doubles as its tag, so a hit needs no data movement.
    logic                pf_active_q,  pf_active_d;
    logic                pf_pending_q, pf_pending_d;
    logic [ADDR_W-1:0]   pend_addr_q,  pend_addr_d;
    logic                buf_valid_q,  buf_valid_d;
    logic                pf_arm_q,     pf_arm_d;

    logic                tag_match;
    logic                join_now;
    logic                redirect_now;
    logic                pf_eff;
    logic                redirect_eff;
    logic [ADDR_W-1:0]   redirect_addr;
`endif

    assign req_fire  = req_valid && req_ready;
    assign last_byte = (idx_q == LAST_IDX);
    assign timed_out = (cnt_q == CNT_LIMIT);

    assign rd_start  = (state_q == ISSUE);
    assign rd_addr   = base_q + ADDR_W'(idx_q);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = asm_q;
    assign rsp_err   = err_q;

`ifdef SPI_FETCH_PREFETCH_EN
    // Classify a request arriving while a speculative fetch is running:
    // a tag hit joins it, anything else redirects once the current byte lands.
    always_comb begin
        tag_match     = (req_addr == base_q);
        join_now      = pf_active_q && req_fire && tag_match;
        redirect_now  = pf_active_q && req_fire && !tag_match;
        pf_eff        = pf_active_q && !join_now;
        redirect_eff  = pf_pending_q || redirect_now;
        redirect_addr = pf_pending_q ? pend_addr_q : req_addr;
    end
`endif

    // Requests are accepted only when idle (and never in the reset cycle);
    // with prefetch enabled a running speculative fetch also accepts one.
    always_comb begin
        req_ready = (state_q == IDLE) && !rst;
`ifdef SPI_FETCH_PREFETCH_EN
        if (pf_active_q && !pf_pending_q && !rst &&
            ((state_q == ISSUE) || (state_q == WAIT))) begin
            req_ready = 1'b1;
        end
`endif
    end

    // Merge the returning byte into its big-endian slot of the assembly word.
    always_comb begin
        asm_with_byte = asm_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IDX_W'(NBYTES - 1 - i)) begin
                asm_with_byte[8*i +: 8] = rd_data;
            end
        end
    end

    // Next-state and datapath update for the fetch sequencer.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef SPI_FETCH_PREFETCH_EN
        pf_active_d  = pf_active_q;
        pf_pending_d = pf_pending_q;
        pend_addr_d  = pend_addr_q;
        buf_valid_d  = buf_valid_q;
        pf_arm_d     = pf_arm_q;
`endif

        unique case (state_q)
            IDLE: begin
`ifdef SPI_FETCH_PREFETCH_EN
                if (req_fire) begin
                    pf_arm_d    = 1'b0;
                    buf_valid_d = 1'b0;
                    err_d       = 1'b0;
                    if (buf_valid_q && tag_match) begin
                        state_d = RESP;
                    end else begin
                        base_d  = req_addr;
                        idx_d   = '0;
                        asm_d   = '0;
                        state_d = ISSUE;
                    end
                end else if (pf_arm_q) begin
                    pf_arm_d    = 1'b0;
                    pf_active_d = 1'b1;
                    base_d      = base_q + ADDR_W'(NBYTES);
                    idx_d       = '0;
                    asm_d       = '0;
                    err_d       = 1'b0;
                    state_d     = ISSUE;
                end
`else
                if (req_fire) begin
                    base_d  = req_addr;
                    idx_d   = '0;
                    asm_d   = '0;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
`endif
            end

            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
`ifdef SPI_FETCH_PREFETCH_EN
                if (join_now) begin
                    pf_active_d = 1'b0;
                end
                if (redirect_now) begin
                    pf_pending_d = 1'b1;
                    pend_addr_d  = req_addr;
                end
`endif
            end

            WAIT: begin
`ifdef SPI_FETCH_PREFETCH_EN
                if (join_now) begin
                    pf_active_d = 1'b0;
                end
                if (redirect_now) begin
                    pf_pending_d = 1'b1;
                    pend_addr_d  = req_addr;
                end
                if (rd_done) begin
                    asm_d = asm_with_byte;
                    if (redirect_eff) begin
                        base_d       = redirect_addr;
                        idx_d        = '0;
                        asm_d        = '0;
                        err_d        = 1'b0;
                        pf_active_d  = 1'b0;
                        pf_pending_d = 1'b0;
                        state_d      = ISSUE;
                    end else if (!last_byte) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ISSUE;
                    end else if (pf_eff) begin
                        pf_active_d = 1'b0;
                        buf_valid_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end else if (timed_out) begin
                    if (redirect_eff) begin
                        pf_active_d  = 1'b0;
                        pf_pending_d = 1'b1;
                        pend_addr_d  = redirect_addr;
                        state_d      = FLUSH;
                    end else if (pf_eff) begin
                        pf_active_d = 1'b0;
                        state_d     = FLUSH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                if (rd_done) begin
                    asm_d = asm_with_byte;
                    if (last_byte) begin
                        state_d = RESP;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ISSUE;
                    end
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d = err_q ? FLUSH : IDLE;
`ifdef SPI_FETCH_PREFETCH_EN
                    pf_arm_d = !err_q;
`endif
                end
            end

            FLUSH: begin
                if (rd_done) begin
`ifdef SPI_FETCH_PREFETCH_EN
                    if (pf_pending_q) begin
                        base_d       = pend_addr_q;
                        idx_d        = '0;
                        asm_d        = '0;
                        err_d        = 1'b0;
                        pf_pending_d = 1'b0;
                        state_d      = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

`ifdef SPI_FETCH_PREFETCH_EN
    // Prefetch registers; reset drops the buffer and any speculative fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pf_active_q  <= 1'b0;
            pf_pending_q <= 1'b0;
            pend_addr_q  <= '0;
            buf_valid_q  <= 1'b0;
            pf_arm_q     <= 1'b0;
        end else begin
            pf_active_q  <= pf_active_d;
            pf_pending_q <= pf_pending_d;
            pend_addr_q  <= pend_addr_d;
            buf_valid_q  <= buf_valid_d;
            pf_arm_q     <= pf_arm_d;
        end
    end
`endif

endmodule

// File: doc/spi_fetch_unit.md
Name: spi_fetch_unit

Overview:
- Request sequencer directly upstream of spi_read_byte; the core issues one fetch, this block drives spi_read_byte once per byte.
- Accepts an address from the core over a valid/ready handshake.
- Issues NBYTES sequential single-byte reads and assembles them big-endian into one word.
- Returns the word over a valid/ready response channel, with a per-byte timeout watchdog flagging a hung SPI transfer.

Parameters:
- ADDR_W, 8, address width (matches spi_read_byte address width).
- NBYTES, 2, bytes per fetch (1..4).
- TIMEOUT, 1023, max cycles to wait for rd_done per byte before error.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset (top derives from ~rst_n)
- req_valid  in  1  core fetch request valid
- req_ready  out  1  unit can accept a request
- req_addr  in  ADDR_W  start byte address
- rsp_valid  out  1  response word valid
- rsp_ready  in  1  core accepts response
- rsp_data  out  8*NBYTES  assembled word; byte at req_addr in MSBs
- rsp_err  out  1  timeout occurred during this fetch
- rd_start  out  1  one-cycle start pulse to spi_read_byte
- rd_addr  out  ADDR_W  byte address to spi_read_byte, stable from rd_start until rd_done
- rd_done  in  1  one-cycle completion pulse from spi_read_byte
- rd_data  in  8  read byte, valid in the rd_done cycle

Behaviour:
- Reset values: req_ready=0 in the reset cycle, then 1; rsp_valid=0, rsp_data=0, rsp_err=0, rd_start=0, rd_addr=0. FSM to IDLE, counters cleared. Reset mid-transfer abandons it immediately, with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP, FLUSH.
- IDLE: req_ready=1. On req_valid&&req_ready at cycle T, latch addr, clear byte index and assembly register, go to ISSUE.
- ISSUE: rd_start=1 for exactly one cycle (T+1 for the first byte); rd_addr = base+index mod 2^ADDR_W (wraps 0xFF->0x00 at ADDR_W=8). Next state WAIT; timeout counter cleared.
- WAIT: on rd_done at cycle D, write rd_data into byte slot (NBYTES-1-index).
  - If not the last byte: index++, ISSUE at D+1.
  - If last byte: rsp_valid=1 at D+1 (RESP).
  - Any rd_done outside WAIT/FLUSH is ignored.
- Timeout: counter increments each WAIT cycle. Reaching TIMEOUT without rd_done sets rsp_err=1; unread slots stay 0x00. Go to RESP, then FLUSH after handshake.
- RESP: rsp_valid, rsp_data and rsp_err are held stable until rsp_ready. On rsp_valid&&rsp_ready, next state is IDLE (or FLUSH if err); rsp_valid drops next cycle. req_ready=0 throughout RESP.
- FLUSH: req_ready=0; wait for the stale rd_done (discarded), then IDLE. Only reset escapes a permanently hung SPI.
- Single outstanding request; no new rd_start until prior rd_done/flush.
- Minimum latency, accept to rsp_valid: NBYTES*(spi latency+1)+1 cycles.

Optional Feature:
- Macro: SPI_FETCH_PREFETCH_EN.
- Enabled:
  - After a clean response for base A, in IDLE the unit speculatively fetches A+NBYTES (mod 2^ADDR_W) into a one-word buffer with a valid tag. req_ready stays 1 during the prefetch.
  - Request matching the tag with buffer full: rsp_valid next cycle, no SPI traffic.
  - Match with the prefetch in flight: join it.
  - Mismatch: finish the current byte read, discard the buffer, start a normal fetch.
  - A prefetch timeout invalidates the buffer silently (no rsp_err).
- Disabled: no buffer or prefetch logic; behaviour exactly as above.

Test Plan:
- RAM[0x12]=0xA5, RAM[0x13]=0x3C, request 0x12, rsp_ready=1 -> two rd_start pulses, rd_addr 0x12 then 0x13; rsp_data=0xA53C, rsp_err=0, rsp_valid exactly one cycle.
- Request 0xFF with RAM[0xFF]=0x11, RAM[0x00]=0x22 -> rd_addr 0xFF then 0x00; rsp_data=0x1122.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid/rsp_data held; req_ready=0 and no rd_start until handshake.
- Stub never asserts rd_done -> rsp_err=1, rsp_data=0x0000 after TIMEOUT cycles; later late rd_done consumed in FLUSH; next request for 0x12 returns 0xA53C.
- Assert rst two cycles after rd_start -> next cycle rsp_valid=0, rd_start=0, FSM IDLE; a fresh request completes normally.
- With SPI_FETCH_PREFETCH_EN: fetch 0x12, then request 0x14 after prefetch completes -> rsp_valid one cycle after accept, no rd_start; then request 0x40 -> normal fetch from 0x40.
